ex_mem_reg: RTL and testbench

EX/MEM pipeline register feeding the data memory stage of the pipelined core. It captures the execute-stage result, store data, destination register and memory/write-back control bits on each clock edge. It supports stall (hold) and flush (bubble). It screens every memory access against the data-memory depth: an out-of-range access is squashed and recorded in a sticky fault register.

---
 rtl/ex_mem_reg.sv | 163 ++++++++++++++++
 tb/tb_ex_mem_reg.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg.sv
// ----------------------------------------------------------------------------
// ex_mem_reg : EX/MEM pipeline register with stall/flush and range screening
//              of data-memory accesses (sticky fault, first address, counter).
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ex_mem_reg #(
  parameter int DEPTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_ex_valid,
  input  logic [31:0]      alu_result,
  input  logic [31:0]      rs2_data,
  input  logic [4:0]       rd,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  input  logic             mem_to_reg,
  input  logic             fault_clr,
  output logic [31:0]      address,
  output logic [31:0]      data_in,
  output logic             we,
  output logic             mem_read_ex_mem,
  output logic             ex_mem_valid,
  output logic [4:0]       ex_mem_rd,
  output logic             ex_mem_reg_write,
  output logic             ex_mem_mem_to_reg,
  output logic             fault,
  output logic [31:0]      fault_addr,
  output logic [CNT_W-1:0] fault_count
);

  localparam logic [31:0]      C_DEPTH   = 32'(DEPTH);
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  logic [31:0]      address_q, address_d;
  logic [31:0]      data_in_q, data_in_d;
  logic             we_q, we_d;
  logic             mem_read_q, mem_read_d;
  logic             valid_q, valid_d;
  logic [4:0]       rd_q, rd_d;
  logic             reg_write_q, reg_write_d;
  logic             mem_to_reg_q, mem_to_reg_d;
  logic             fault_q, fault_d;
  logic [31:0]      fault_addr_q, fault_addr_d;
  logic [CNT_W-1:0] fault_count_q, fault_count_d;

  logic w_load;
  logic w_oor;
  logic w_oor_load;

  always_comb begin
    w_load     = ~flush & ~stall;
    w_oor      = id_ex_valid & (mem_read | mem_write) & (alu_result >= C_DEPTH);
    w_oor_load = w_load & w_oor;

    address_d    = address_q;
    data_in_d    = data_in_q;
    we_d         = we_q;
    mem_read_d   = mem_read_q;
    valid_d      = valid_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;

    if (flush) begin
      address_d    = '0;
      data_in_d    = '0;
      we_d         = 1'b0;
      mem_read_d   = 1'b0;
      valid_d      = 1'b0;
      rd_d         = '0;
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
    end else if (w_load) begin
      address_d    = alu_result;
      data_in_d    = rs2_data;
      valid_d      = id_ex_valid;
      rd_d         = rd;
      we_d         = id_ex_valid & mem_write & ~w_oor;
      // A combined read+write keeps only the write.
      mem_read_d   = id_ex_valid & mem_read & ~mem_write & ~w_oor;
      reg_write_d  = id_ex_valid & reg_write & ~w_oor;
      mem_to_reg_d = id_ex_valid & mem_to_reg;
    end
  end

  always_comb begin
    fault_d       = fault_q;
    fault_addr_d  = fault_addr_q;
    fault_count_d = fault_count_q;

    if (w_oor_load) begin
      // A clear on the same edge as a new fault restarts from that fault.
      if (fault_clr) begin
        fault_d       = 1'b1;
        fault_addr_d  = alu_result;
        fault_count_d = C_CNT_ONE;
      end else begin
        if (!fault_q) begin
          fault_d      = 1'b1;
          fault_addr_d = alu_result;
        end
        if (fault_count_q != C_CNT_MAX) begin
          fault_count_d = fault_count_q + C_CNT_ONE;
        end
      end
    end else if (fault_clr) begin
      fault_d       = 1'b0;
      fault_addr_d  = '0;
      fault_count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      address_q     <= '0;
      data_in_q     <= '0;
      we_q          <= 1'b0;
      mem_read_q    <= 1'b0;
      valid_q       <= 1'b0;
      rd_q          <= '0;
      reg_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      fault_q       <= 1'b0;
      fault_addr_q  <= '0;
      fault_count_q <= '0;
    end else begin
      address_q     <= address_d;
      data_in_q     <= data_in_d;
      we_q          <= we_d;
      mem_read_q    <= mem_read_d;
      valid_q       <= valid_d;
      rd_q          <= rd_d;
      reg_write_q   <= reg_write_d;
      mem_to_reg_q  <= mem_to_reg_d;
      fault_q       <= fault_d;
      fault_addr_q  <= fault_addr_d;
      fault_count_q <= fault_count_d;
    end
  end

  assign address           = address_q;
  assign data_in           = data_in_q;
  assign we                = we_q;
  assign mem_read_ex_mem   = mem_read_q;
  assign ex_mem_valid      = valid_q;
  assign ex_mem_rd         = rd_q;
  assign ex_mem_reg_write  = reg_write_q;
  assign ex_mem_mem_to_reg = mem_to_reg_q;
  assign fault             = fault_q;
  assign fault_addr        = fault_addr_q;
  assign fault_count       = fault_count_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_reg.sv
// ----------------------------------------------------------------------------
// tb_ex_mem_reg : directed scoreboard bench for ex_mem_reg (DEPTH=32, CNT_W=2).
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ex_mem_reg;

  localparam int C_DEPTH = 32;
  localparam int C_CNT_W = 2;

  logic              clk;
  logic              rst;
  logic              stall;
  logic              flush;
  logic              id_ex_valid;
  logic [31:0]       alu_result;
  logic [31:0]       rs2_data;
  logic [4:0]        rd;
  logic              mem_read;
  logic              mem_write;
  logic              reg_write;
  logic              mem_to_reg;
  logic              fault_clr;
  logic [31:0]       address;
  logic [31:0]       data_in;
  logic              we;
  logic              mem_read_ex_mem;
  logic              ex_mem_valid;
  logic [4:0]        ex_mem_rd;
  logic              ex_mem_reg_write;
  logic              ex_mem_mem_to_reg;
  logic              fault;
  logic [31:0]       fault_addr;
  logic [C_CNT_W-1:0] fault_count;

  ex_mem_reg #(.DEPTH(C_DEPTH), .CNT_W(C_CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .flush             (flush),
    .id_ex_valid       (id_ex_valid),
    .alu_result        (alu_result),
    .rs2_data          (rs2_data),
    .rd                (rd),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .reg_write         (reg_write),
    .mem_to_reg        (mem_to_reg),
    .fault_clr         (fault_clr),
    .address           (address),
    .data_in           (data_in),
    .we                (we),
    .mem_read_ex_mem   (mem_read_ex_mem),
    .ex_mem_valid      (ex_mem_valid),
    .ex_mem_rd         (ex_mem_rd),
    .ex_mem_reg_write  (ex_mem_reg_write),
    .ex_mem_mem_to_reg (ex_mem_mem_to_reg),
    .fault             (fault),
    .fault_addr        (fault_addr),
    .fault_count       (fault_count)
  );

  typedef struct {
    string              tag;
    logic [31:0]        addr;
    logic [31:0]        din;
    logic               we;
    logic               mrd;
    logic               valid;
    logic [4:0]         rd;
    logic               rw;
    logic               m2r;
    logic               f;
    logic [31:0]        faddr;
    logic [C_CNT_W-1:0] fcnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input string tag, input logic [31:0] addr, input logic [31:0] din,
                              input logic we_e, input logic mrd, input logic valid, input logic [4:0] rd_e,
                              input logic rw, input logic m2r, input logic f, input logic [31:0] faddr,
                              input logic [C_CNT_W-1:0] fcnt);
    exp_t e;
    e.tag = tag; e.addr = addr; e.din = din; e.we = we_e; e.mrd = mrd; e.valid = valid;
    e.rd = rd_e; e.rw = rw; e.m2r = m2r; e.f = f; e.faddr = faddr; e.fcnt = fcnt;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    chk({e.tag, ".address"},  address,                    e.addr);
    chk({e.tag, ".data_in"},  data_in,                    e.din);
    chk({e.tag, ".we"},       {31'd0, we},                {31'd0, e.we});
    chk({e.tag, ".mem_read"}, {31'd0, mem_read_ex_mem},   {31'd0, e.mrd});
    chk({e.tag, ".valid"},    {31'd0, ex_mem_valid},      {31'd0, e.valid});
    chk({e.tag, ".rd"},       {27'd0, ex_mem_rd},         {27'd0, e.rd});
    chk({e.tag, ".reg_wr"},   {31'd0, ex_mem_reg_write},  {31'd0, e.rw});
    chk({e.tag, ".mem2reg"},  {31'd0, ex_mem_mem_to_reg}, {31'd0, e.m2r});
    chk({e.tag, ".fault"},    {31'd0, fault},             {31'd0, e.f});
    chk({e.tag, ".f_addr"},   fault_addr,                 e.faddr);
    chk({e.tag, ".f_count"},  32'(fault_count),           32'(e.fcnt));
  endtask

  task automatic drive(input logic st, input logic fl, input logic clr, input logic v,
                       input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd_i,
                       input logic mr, input logic mw, input logic rw, input logic m2r);
    stall = st; flush = fl; fault_clr = clr; id_ex_valid = v; alu_result = alu; rs2_data = rs2;
    rd = rd_i; mem_read = mr; mem_write = mw; reg_write = rw; mem_to_reg = m2r;
  endtask

  // Expected result queued with the stimulus, checked one edge later.
  task automatic tick(input exp_t e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare_head();
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 1, 32'h1, 32'h2, 5'd9, 0, 1, 1, 1);
    repeat (2) @(posedge clk);
    #1;
    sb_q.push_back(mk("reset_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    compare_head();
    #3 rst = 1'b0;

    // store then load
    drive(0, 0, 0, 1, 32'd5, 32'hDEADBEEF, 5'd0, 0, 1, 0, 0);
    tick(mk("sw5", 32'd5, 32'hDEADBEEF, 1, 0, 1, 5'd0, 0, 0, 0, 0, 0));
    drive(0, 0, 0, 1, 32'd5, 32'h11, 5'd3, 1, 0, 1, 1);
    tick(mk("lw5", 32'd5, 32'h11, 0, 1, 1, 5'd3, 1, 1, 0, 0, 0));

    // large non-memory result is not a fault
    drive(0, 0, 0, 1, 32'h1234, 32'h22, 5'd7, 0, 0, 1, 0);
    tick(mk("add7", 32'h1234, 32'h22, 0, 0, 1, 5'd7, 1, 0, 0, 0, 0));

    // stall with an out-of-range store presented: nothing moves, no fault
    drive(1, 0, 0, 1, 32'h40, 32'h99, 5'd2, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      tick(mk("stall", 32'h1234, 32'h22, 0, 0, 1, 5'd7, 1, 0, 0, 0, 0));

    drive(1, 1, 0, 1, 32'h40, 32'h99, 5'd2, 0, 1, 0, 0);
    tick(mk("stall_flush", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // out-of-range accesses
    drive(0, 0, 0, 1, 32'd40, 32'hAA, 5'd0, 0, 1, 0, 0);
    tick(mk("sw40", 32'd40, 32'hAA, 0, 0, 1, 5'd0, 0, 0, 1, 32'd40, 1));
    drive(0, 0, 0, 1, 32'd100, 32'hBB, 5'd4, 1, 0, 1, 1);
    tick(mk("lw100", 32'd100, 32'hBB, 0, 0, 1, 5'd4, 0, 1, 1, 32'd40, 2));
    drive(0, 0, 0, 1, 32'd31, 32'hCC, 5'd0, 0, 1, 0, 0);
    tick(mk("sw31_edge", 32'd31, 32'hCC, 1, 0, 1, 5'd0, 0, 0, 1, 32'd40, 2));

    // clear colliding with a new fault, then clear alone with a bubble
    drive(0, 0, 1, 1, 32'd33, 32'hDD, 5'd0, 0, 1, 0, 0);
    tick(mk("clr_sw33", 32'd33, 32'hDD, 0, 0, 1, 5'd0, 0, 0, 1, 32'd33, 1));
    drive(0, 0, 1, 0, 32'd999, 32'h0, 5'd0, 0, 1, 0, 0);
    tick(mk("clr_bubble", 32'd999, 32'h0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0));

    // saturation of the 2-bit counter, starting at address == DEPTH
    drive(0, 0, 0, 1, 32'd32, 32'h1, 5'd1, 1, 0, 1, 1);
    tick(mk("lw32", 32'd32, 32'h1, 0, 0, 1, 5'd1, 0, 1, 1, 32'd32, 1));
    drive(0, 0, 0, 1, 32'hFFFFFFFF, 32'h2, 5'd0, 0, 1, 0, 0);
    tick(mk("sw_max", 32'hFFFFFFFF, 32'h2, 0, 0, 1, 5'd0, 0, 0, 1, 32'd32, 2));
    drive(0, 0, 0, 1, 32'd50, 32'h3, 5'd0, 0, 1, 0, 0);
    tick(mk("sw50", 32'd50, 32'h3, 0, 0, 1, 5'd0, 0, 0, 1, 32'd32, 3));
    drive(0, 0, 0, 1, 32'd60, 32'h4, 5'd0, 0, 1, 0, 0);
    tick(mk("sw60_sat", 32'd60, 32'h4, 0, 0, 1, 5'd0, 0, 0, 1, 32'd32, 3));
    drive(0, 0, 0, 1, 32'd70, 32'h5, 5'd0, 0, 1, 0, 0);
    tick(mk("sw70_sat", 32'd70, 32'h5, 0, 0, 1, 5'd0, 0, 0, 1, 32'd32, 3));
    drive(0, 0, 0, 0, 32'd999, 32'h6, 5'd0, 0, 1, 0, 0);
    tick(mk("bubble999", 32'd999, 32'h6, 0, 0, 0, 5'd0, 0, 0, 1, 32'd32, 3));

    // flush leaves fault state alone; flush with clear still clears
    drive(0, 1, 0, 1, 32'd80, 32'h7, 5'd5, 0, 1, 0, 0);
    tick(mk("flush_keep", 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'd32, 3));
    drive(0, 1, 1, 1, 32'd80, 32'h7, 5'd5, 0, 1, 0, 0);
    tick(mk("flush_clr", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // read+write together: write wins
    drive(0, 0, 0, 1, 32'd10, 32'h8, 5'd6, 1, 1, 1, 0);
    tick(mk("rw_both", 32'd10, 32'h8, 1, 0, 1, 5'd6, 1, 0, 0, 0, 0));
    drive(0, 0, 0, 1, 32'd45, 32'h9, 5'd0, 0, 1, 0, 0);
    tick(mk("sw45", 32'd45, 32'h9, 0, 0, 1, 5'd0, 0, 0, 1, 32'd45, 1));

    // asynchronous reset mid-cycle
    drive(0, 0, 0, 1, 32'd12, 32'hA, 5'd8, 0, 1, 1, 1);
    tick(mk("pre_rst", 32'd12, 32'hA, 1, 0, 1, 5'd8, 1, 1, 1, 32'd45, 1));
    #2 rst = 1'b1;
    #1;
    sb_q.push_back(mk("async_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    compare_head();
    #1 rst = 1'b0;
    tick(mk("post_rst", 32'd12, 32'hA, 1, 0, 1, 5'd8, 1, 1, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
